cpu_controller: RTL and testbench
=================================

Name: cpu_controller

Overview:
Control unit that sits directly upstream of the register-file/ALU datapath. It holds the 16-bit instruction register and decodes its fields. A Moore FSM sequences the datapath load/write strobes for the MOV, ADD, CMP, AND and MVN instructions. It exposes a start/wait handshake to the top level and supplies the sign-extended immediates the datapath consumes.

Parameters:
none

Ports:
clk       in   1   rising-edge clock
reset     in   1   asynchronous, active-high; forces state WAIT and clears IR
in        in   16  instruction word
load      in   1   IR load enable (honoured only in WAIT)
s         in   1   start; sampled in WAIT
w         out  1   1 = idle in WAIT, ready for load/s
readnum   out  3   datapath read register select
writenum  out  3   datapath write register select
vsel      out  2   write-back mux select (00 = C, 10 = sximm8)
loada     out  1   A register load strobe
loadb     out  1   B register load strobe
shift     out  2   shifter op
asel      out  1   ALU A-input select (1 = zero)
bsel      out  1   ALU B-input select (fixed 0)
ALUop     out  2   ALU op
loadc     out  1   C register load strobe
loads     out  1   status register load strobe
write     out  1   register-file write enable
sximm8    out  16  sign-extended IR[7:0]
sximm5    out  16  sign-extended IR[4:0]

Behaviour:
- Instruction fields:
  - opcode = IR[15:13], op = IR[12:11], Rn = IR[10:8], Rd = IR[7:5], sh = IR[4:3], Rm = IR[2:0].
- IR update:
  - IR <= in on a rising edge when load = 1 and state = WAIT.
  - load in any other state is ignored.
- Combinational outputs, decoded from IR in every state:
  - shift = sh; ALUop = op; asel = (opcode == 110); bsel = 0.
  - sximm8 = {{8{IR[7]}}, IR[7:0]}; sximm5 = {{11{IR[4]}}, IR[4:0]}.
- Default register selects:
  - readnum = Rm, except GET_A, where readnum = Rn.
  - writenum = Rd, except WRITE_IMM, where writenum = Rn.
  - vsel = 00, except WRITE_IMM, where vsel = 10.
- Strobes: loada, loadb, loadc, loads and write are 0 except in the states listed below. w = 1 only in WAIT.
- States and transitions:
  - WAIT: s = 1 -> DECODE; otherwise stay.
  - DECODE: no strobes. Next state by {opcode, op}:
    - 110_10 (MOV imm) -> WRITE_IMM.
    - 110_00 (MOV reg) -> GET_B.
    - 101_11 (MVN) -> GET_B.
    - 101_00/01/10 (ADD/CMP/AND) -> GET_A.
    - anything else -> WAIT (no-op).
  - GET_A: loada = 1 -> GET_B.
  - GET_B: loadb = 1 -> EXEC.
  - EXEC:
    - CMP: loads = 1 -> WAIT.
    - All others: loadc = 1 -> WRITE_REG.
  - WRITE_REG: write = 1 -> WAIT.
  - WRITE_IMM: write = 1 -> WAIT.
- Instruction latency in edges from the edge that leaves WAIT back to w = 1:
  - MOV imm: 3.
  - MOV reg / MVN: 5.
  - ADD / AND: 6.
  - CMP: 5.
  - Undefined opcode: 2.
- Simultaneous load and s in WAIT: IR captures `in` on the same edge FSM enters DECODE; DECODE uses the new IR.
- s held high: a new instruction starts on the first cycle back in WAIT.
- Reset (including mid-instruction): immediately state = WAIT, IR = 0, all strobes 0, w = 1. With IR = 0 every decoded output is 0.

Test Plan:
1. Reset, then in=0xD007, load=1, s=1 for one cycle -> w=0; on the 2nd cycle after start, write=1, writenum=0, vsel=10, sximm8=0x0007; w=1 after edge 3.
2. in=0xD1FE (MOV R1,#-2) -> sximm8=0xFFFE, writenum=1 during WRITE_IMM.
3. in=0xA148 (ADD R2,R1,R0,LSL#1) -> GET_A: readnum=1, loada; GET_B: readnum=0, loadb; EXEC: shift=01, ALUop=00, asel=0, loadc; WRITE_REG: writenum=2, vsel=00, write; w=1 after 6 edges.
4. in=0xAA00 (CMP R2,R0) -> EXEC: ALUop=01, loads=1, loadc=0; write never asserted; w=1 after 5 edges.
5. in=0xC071 (MOV R3,R1,LSR#1) -> no loada; GET_B: readnum=1; EXEC: asel=1, shift=10, ALUop=00; WRITE_REG: writenum=3.
6. Negative cases, with IR checked afterwards:
   - load=1 with in=0xFFFF during GET_B -> IR unchanged.
   - reset asserted in EXEC -> w=1 and all strobes 0 without waiting for a clock.
   - in=0x0000 with s=1 -> back to WAIT after 2 edges with no strobes asserted.

Source files
------------

// File: rtl/cpu_controller.sv
// cpu_controller: instruction register, field decode and Moore sequencer for
// the MOV/ADD/CMP/AND/MVN datapath strobes.
module cpu_controller (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] in,
   input  logic        load,
   input  logic        s,
   output logic        w,
   output logic [2:0]  readnum,
   output logic [2:0]  writenum,
   output logic [1:0]  vsel,
   output logic        loada,
   output logic        loadb,
   output logic [1:0]  shift,
   output logic        asel,
   output logic        bsel,
   output logic [1:0]  ALUop,
   output logic        loadc,
   output logic        loads,
   output logic        write,
   output logic [15:0] sximm8,
   output logic [15:0] sximm5
);

   localparam logic [2:0] ST_WAIT      = 3'd0;
   localparam logic [2:0] ST_DECODE    = 3'd1;
   localparam logic [2:0] ST_GET_A     = 3'd2;
   localparam logic [2:0] ST_GET_B     = 3'd3;
   localparam logic [2:0] ST_EXEC      = 3'd4;
   localparam logic [2:0] ST_WRITE_REG = 3'd5;
   localparam logic [2:0] ST_WRITE_IMM = 3'd6;

   logic [15:0] ir;
   logic [2:0]  state;
   logic [2:0]  state_next;

   logic [2:0] opcode;
   logic [1:0] op;
   logic [2:0] rn;
   logic [2:0] rd;
   logic [2:0] rm;

   assign opcode = ir[15:13];
   assign op     = ir[12:11];
   assign rn     = ir[10:8];
   assign rd     = ir[7:5];
   assign rm     = ir[2:0];

   // Field decode that is independent of the sequencer state.
   assign shift  = ir[4:3];
   assign ALUop  = op;
   assign asel   = (opcode == 3'b110);
   assign bsel   = 1'b0;
   assign sximm8 = {{8{ir[7]}}, ir[7:0]};
   assign sximm5 = {{11{ir[4]}}, ir[4:0]};

   // Instruction register: only accepts a new word while idle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         ir <= 16'h0000;
      else if (load && (state == ST_WAIT))
         ir <= in;
   end

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state <= ST_WAIT;
      else
         state <= state_next;
   end

   // Next-state and Moore outputs.
   always_comb begin
      state_next = state;
      w          = 1'b0;
      readnum    = rm;
      writenum   = rd;
      vsel       = 2'b00;
      loada      = 1'b0;
      loadb      = 1'b0;
      loadc      = 1'b0;
      loads      = 1'b0;
      write      = 1'b0;
      case (state)
         ST_WAIT: begin
            w = 1'b1;
            if (s)
               state_next = ST_DECODE;
         end
         ST_DECODE: begin
            case ({opcode, op})
               5'b110_10: state_next = ST_WRITE_IMM;
               5'b110_00: state_next = ST_GET_B;
               5'b101_11: state_next = ST_GET_B;
               5'b101_00,
               5'b101_01,
               5'b101_10: state_next = ST_GET_A;
               default:   state_next = ST_WAIT;
            endcase
         end
         ST_GET_A: begin
            readnum    = rn;
            loada      = 1'b1;
            state_next = ST_GET_B;
         end
         ST_GET_B: begin
            loadb      = 1'b1;
            state_next = ST_EXEC;
         end
         ST_EXEC: begin
            // CMP only updates status; everything else writes back.
            if ({opcode, op} == 5'b101_01) begin
               loads      = 1'b1;
               state_next = ST_WAIT;
            end else begin
               loadc      = 1'b1;
               state_next = ST_WRITE_REG;
            end
         end
         ST_WRITE_REG: begin
            write      = 1'b1;
            state_next = ST_WAIT;
         end
         ST_WRITE_IMM: begin
            writenum   = rn;
            vsel       = 2'b10;
            write      = 1'b1;
            state_next = ST_WAIT;
         end
         default: state_next = ST_WAIT;
      endcase
   end

endmodule

// File: tb/tb_cpu_controller.sv
// Directed testbench for cpu_controller.
module tb_cpu_controller;

   logic        clk;
   logic        reset;
   logic [15:0] in;
   logic        load;
   logic        s;
   logic        w;
   logic [2:0]  readnum;
   logic [2:0]  writenum;
   logic [1:0]  vsel;
   logic        loada;
   logic        loadb;
   logic [1:0]  shift;
   logic        asel;
   logic        bsel;
   logic [1:0]  ALUop;
   logic        loadc;
   logic        loads;
   logic        write;
   logic [15:0] sximm8;
   logic [15:0] sximm5;

   int tests;
   int fails;

   cpu_controller dut (
      .clk(clk), .reset(reset), .in(in), .load(load), .s(s), .w(w),
      .readnum(readnum), .writenum(writenum), .vsel(vsel),
      .loada(loada), .loadb(loadb), .shift(shift), .asel(asel), .bsel(bsel),
      .ALUop(ALUop), .loadc(loadc), .loads(loads), .write(write),
      .sximm8(sximm8), .sximm5(sximm5)
   );

   // 10 ns clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Strobe vector {loada, loadb, loadc, loads, write}.
   function automatic logic [4:0] strobes();
      return {loada, loadb, loadc, loads, write};
   endfunction

   // Advance one rising edge and settle.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; in = 16'h0; load = 1'b0; s = 1'b0;
      tick(); tick();
      tests++;
      if (w !== 1'b1 || strobes() !== 5'b0) begin
         fails++; $display("FAIL reset_idle: w=%b strobes=%b, want w=1 strobes=00000", w, strobes());
      end
      tests++;
      if (sximm8 !== 16'h0 || sximm5 !== 16'h0 || readnum !== 3'd0 || writenum !== 3'd0 ||
          vsel !== 2'b00 || shift !== 2'b00 || ALUop !== 2'b00 || asel !== 1'b0 || bsel !== 1'b0) begin
         fails++; $display("FAIL reset_decode: sximm8=%h sximm5=%h rn=%0d wn=%0d vsel=%b sh=%b op=%b asel=%b bsel=%b, want all 0",
                           sximm8, sximm5, readnum, writenum, vsel, shift, ALUop, asel, bsel);
      end
      reset = 1'b0;
   endtask

   // MOV immediate; issued with load and s together so DECODE must see new IR.
   task automatic test_mov_imm(input logic [15:0] instr, input logic [2:0] exp_wn,
                               input logic [15:0] exp_imm);
      in = instr; load = 1'b1; s = 1'b1;
      tick();
      load = 1'b0; s = 1'b0;
      tests++;
      if (w !== 1'b0 || strobes() !== 5'b0) begin
         fails++; $display("FAIL movi_decode %h: w=%b strobes=%b, want w=0 strobes=00000", instr, w, strobes());
      end
      tick();
      tests++;
      if (strobes() !== 5'b00001 || writenum !== exp_wn || vsel !== 2'b10 || sximm8 !== exp_imm || w !== 1'b0) begin
         fails++; $display("FAIL movi_write %h: strobes=%b wn=%0d vsel=%b sximm8=%h w=%b, want 00001 %0d 10 %h 0",
                           instr, strobes(), writenum, vsel, sximm8, w, exp_wn, exp_imm);
      end
      tick();
      tests++;
      if (w !== 1'b1 || strobes() !== 5'b0) begin
         fails++; $display("FAIL movi_done %h: w=%b strobes=%b, want w=1 strobes=00000", instr, w, strobes());
      end
   endtask

   // ADD R2,R1,R0,LSL#1.
   task automatic test_add();
      in = 16'hA148; load = 1'b1; s = 1'b1;
      tick();
      load = 1'b0; s = 1'b0;
      tick();
      tests++;
      if (strobes() !== 5'b10000 || readnum !== 3'd1) begin
         fails++; $display("FAIL add_get_a: strobes=%b readnum=%0d, want 10000 1", strobes(), readnum);
      end
      tick();
      tests++;
      if (strobes() !== 5'b01000 || readnum !== 3'd0) begin
         fails++; $display("FAIL add_get_b: strobes=%b readnum=%0d, want 01000 0", strobes(), readnum);
      end
      tick();
      tests++;
      if (strobes() !== 5'b00100 || shift !== 2'b01 || ALUop !== 2'b00 || asel !== 1'b0 || bsel !== 1'b0) begin
         fails++; $display("FAIL add_exec: strobes=%b shift=%b ALUop=%b asel=%b bsel=%b, want 00100 01 00 0 0",
                           strobes(), shift, ALUop, asel, bsel);
      end
      tick();
      tests++;
      if (strobes() !== 5'b00001 || writenum !== 3'd2 || vsel !== 2'b00 || w !== 1'b0) begin
         fails++; $display("FAIL add_write: strobes=%b wn=%0d vsel=%b w=%b, want 00001 2 00 0", strobes(), writenum, vsel, w);
      end
      tick();
      tests++;
      if (w !== 1'b1) begin
         fails++; $display("FAIL add_latency: w=%b after 6 edges, want 1", w);
      end
   endtask

   // CMP R2,R0: status load only, never writes.
   task automatic test_cmp();
      logic wrote;
      wrote = 1'b0;
      in = 16'hAA00; load = 1'b1; s = 1'b1;
      tick();
      load = 1'b0; s = 1'b0;
      wrote |= write;
      tick(); wrote |= write;
      tests++;
      if (strobes() !== 5'b10000 || readnum !== 3'd2) begin
         fails++; $display("FAIL cmp_get_a: strobes=%b readnum=%0d, want 10000 2", strobes(), readnum);
      end
      tick(); wrote |= write;
      tick(); wrote |= write;
      tests++;
      if (ALUop !== 2'b01 || loads !== 1'b1 || loadc !== 1'b0) begin
         fails++; $display("FAIL cmp_exec: ALUop=%b loads=%b loadc=%b, want 01 1 0", ALUop, loads, loadc);
      end
      tick(); wrote |= write;
      tests++;
      if (w !== 1'b1 || wrote !== 1'b0) begin
         fails++; $display("FAIL cmp_done: w=%b wrote=%b, want w=1 wrote=0", w, wrote);
      end
   endtask

   // MOV R3,R1,LSR#1: skips GET_A, zero on ALU A input.
   task automatic test_mov_reg();
      logic a_seen;
      a_seen = 1'b0;
      in = 16'hC071; load = 1'b1; s = 1'b1;
      tick();
      load = 1'b0; s = 1'b0;
      tick(); a_seen |= loada;
      tests++;
      if (strobes() !== 5'b01000 || readnum !== 3'd1) begin
         fails++; $display("FAIL movr_get_b: strobes=%b readnum=%0d, want 01000 1", strobes(), readnum);
      end
      tick(); a_seen |= loada;
      tests++;
      if (strobes() !== 5'b00100 || asel !== 1'b1 || shift !== 2'b10 || ALUop !== 2'b00) begin
         fails++; $display("FAIL movr_exec: strobes=%b asel=%b shift=%b ALUop=%b, want 00100 1 10 00",
                           strobes(), asel, shift, ALUop);
      end
      tick(); a_seen |= loada;
      tests++;
      if (strobes() !== 5'b00001 || writenum !== 3'd3 || vsel !== 2'b00) begin
         fails++; $display("FAIL movr_write: strobes=%b wn=%0d vsel=%b, want 00001 3 00", strobes(), writenum, vsel);
      end
      tick();
      tests++;
      if (w !== 1'b1 || a_seen !== 1'b0) begin
         fails++; $display("FAIL movr_done: w=%b loada_seen=%b, want 1 0", w, a_seen);
      end
   endtask

   // MVN R7,R0: same path as MOV reg, 5 edges.
   task automatic test_mvn();
      in = 16'hB8E0; load = 1'b1; s = 1'b1;
      tick();
      load = 1'b0; s = 1'b0;
      tick();
      tests++;
      if (strobes() !== 5'b01000) begin
         fails++; $display("FAIL mvn_get_b: strobes=%b, want 01000", strobes());
      end
      tick();
      tests++;
      if (strobes() !== 5'b00100 || ALUop !== 2'b11) begin
         fails++; $display("FAIL mvn_exec: strobes=%b ALUop=%b, want 00100 11", strobes(), ALUop);
      end
      tick();
      tests++;
      if (strobes() !== 5'b00001 || writenum !== 3'd7) begin
         fails++; $display("FAIL mvn_write: strobes=%b wn=%0d, want 00001 7", strobes(), writenum);
      end
      tick();
      tests++;
      if (w !== 1'b1) begin
         fails++; $display("FAIL mvn_latency: w=%b after 5 edges, want 1", w);
      end
   endtask

   // Load mid-instruction ignored, then async reset from EXEC.
   task automatic test_load_ignored_and_reset();
      in = 16'hC071; load = 1'b1; s = 1'b1;
      tick();
      load = 1'b0; s = 1'b0;
      tick();
      in = 16'hFFFF; load = 1'b1;
      tick();
      load = 1'b0;
      tests++;
      if (sximm8 !== 16'h0071 || loadc !== 1'b1 || shift !== 2'b10) begin
         fails++; $display("FAIL ir_hold: sximm8=%h loadc=%b shift=%b, want 0071 1 10", sximm8, loadc, shift);
      end
      #2;
      reset = 1'b1;
      #1;
      tests++;
      if (w !== 1'b1 || strobes() !== 5'b0 || sximm8 !== 16'h0 || asel !== 1'b0) begin
         fails++; $display("FAIL async_reset: w=%b strobes=%b sximm8=%h asel=%b, want 1 00000 0000 0",
                           w, strobes(), sximm8, asel);
      end
      tick();
      reset = 1'b0;
   endtask

   // Undefined opcode returns to WAIT after 2 edges with no strobes.
   task automatic test_undefined();
      logic [4:0] seen;
      seen = 5'b0;
      in = 16'h0000; load = 1'b1; s = 1'b1;
      tick();
      load = 1'b0; s = 1'b0;
      seen |= strobes();
      tests++;
      if (w !== 1'b0) begin
         fails++; $display("FAIL undef_decode: w=%b, want 0", w);
      end
      tick();
      seen |= strobes();
      tests++;
      if (w !== 1'b1 || seen !== 5'b0) begin
         fails++; $display("FAIL undef_done: w=%b strobes_seen=%b, want 1 00000", w, seen);
      end
   endtask

   // s held high restarts immediately on return to WAIT.
   task automatic test_back_to_back();
      int guard;
      in = 16'hD205; load = 1'b1; s = 1'b1;
      tick();
      load = 1'b0;
      tick();
      tick();
      tests++;
      if (w !== 1'b1) begin
         fails++; $display("FAIL b2b_wait: w=%b, want 1", w);
      end
      tick();
      tests++;
      if (w !== 1'b0) begin
         fails++; $display("FAIL b2b_restart: w=%b, want 0", w);
      end
      s = 1'b0;
      tick();
      tests++;
      if (write !== 1'b1 || writenum !== 3'd2 || sximm8 !== 16'h0005) begin
         fails++; $display("FAIL b2b_write: write=%b wn=%0d sximm8=%h, want 1 2 0005", write, writenum, sximm8);
      end
      guard = 0;
      while (w !== 1'b1 && guard < 10) begin
         tick();
         guard++;
      end
      tests++;
      if (w !== 1'b1) begin
         fails++; $display("FAIL b2b_timeout: w=%b, want 1 within 10 edges", w);
      end
   endtask

   initial begin
      tests = 0;
      fails = 0;
      test_reset();
      test_mov_imm(16'hD007, 3'd0, 16'h0007);
      test_mov_imm(16'hD1FE, 3'd1, 16'hFFFE);
      test_add();
      test_cmp();
      test_mov_reg();
      test_mvn();
      test_load_ignored_and_reset();
      test_undefined();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
